led_pwm_driver: RTL



---
 rtl/led_pkg.sv | 21 ++
 rtl/led_pwm_timebase.sv | 49 ++++
 rtl/led_pwm_driver.sv | 104 ++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// ============================================================================
// led_pkg : shared constants and helpers for the LED PWM driver slice
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package led_pkg;

    localparam int LED_PWM_BITS     = 8;
    localparam int LED_PWM_PRESCALE = 4;
    localparam int LED_BLINK_CYCLES = 50_000_000;
    localparam int LED_COUNT        = 16;

    // Counter width for a 0..n-1 counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_pwm_timebase.sv
// ============================================================================
// led_pwm_timebase : prescaled PWM step counter with step and frame-wrap strobes
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module led_pwm_timebase
    import led_pkg::*;
#(
    parameter int PWM_BITS     = LED_PWM_BITS,
    parameter int PWM_PRESCALE = LED_PWM_PRESCALE
) (
    input  logic                clk,
    input  logic                resetn,
    output logic [PWM_BITS-1:0] pwm_cnt_o,
    output logic                step_tick_o,
    output logic                wrap_o
);

    localparam int            PW        = cnt_width(PWM_PRESCALE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PWM_PRESCALE - 1);

    logic [PW-1:0]       presc_cnt_q;
    logic [PW-1:0]       presc_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;

    assign step_tick_o = (presc_cnt_q == PRESC_MAX);
    assign wrap_o      = step_tick_o && (pwm_cnt_q == '1);
    assign pwm_cnt_o   = pwm_cnt_q;

    always_comb begin
        presc_cnt_d = step_tick_o ? '0 : presc_cnt_q + 1'b1;
        pwm_cnt_d   = step_tick_o ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_pwm_driver.sv
// ============================================================================
// led_pwm_driver : frame-shadowed PWM dimming and per-LED blinking for 16 pins
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module led_pwm_driver
    import led_pkg::*;
#(
    parameter int PWM_BITS     = LED_PWM_BITS,
    parameter int PWM_PRESCALE = LED_PWM_PRESCALE,
    parameter int BLINK_CYCLES = LED_BLINK_CYCLES
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [LED_COUNT-1:0] leds_in,
    input  logic [LED_COUNT-1:0] blink_mask,
    input  logic                 blink_enable,
    input  logic [PWM_BITS-1:0]  brightness,
    output logic [LED_COUNT-1:0] led_pins,
    output logic                 blink_phase,
    output logic                 frame_start
);

    localparam int            BW        = cnt_width(BLINK_CYCLES);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    logic [PWM_BITS-1:0]  w_pwm_cnt;
    logic                 w_step_tick;
    logic                 w_wrap;
    logic                 w_load;
    logic                 w_pwm_on;

    logic [LED_COUNT-1:0] leds_sh_q,   leds_sh_d;
    logic [LED_COUNT-1:0] mask_sh_q,   mask_sh_d;
    logic [PWM_BITS-1:0]  bright_sh_q, bright_sh_d;
    logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic [LED_COUNT-1:0] led_pins_q,  led_pins_d;
    logic                 frame_start_q;

    led_pwm_timebase #(
        .PWM_BITS     (PWM_BITS),
        .PWM_PRESCALE (PWM_PRESCALE)
    ) u_timebase (
        .clk         (clk),
        .resetn      (resetn),
        .pwm_cnt_o   (w_pwm_cnt),
        .step_tick_o (w_step_tick),
        .wrap_o      (w_wrap)
    );

    assign w_load   = w_wrap & w_step_tick;
    // Full scale is forced on so the last step of the frame is lit too.
    assign w_pwm_on = (bright_sh_q == '1) || (w_pwm_cnt < bright_sh_q);

    always_comb begin
        leds_sh_d   = w_load ? leds_in    : leds_sh_q;
        mask_sh_d   = w_load ? blink_mask : mask_sh_q;
        bright_sh_d = w_load ? brightness : bright_sh_q;

        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!blink_enable) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + 1'b1;
        end

        led_pins_d = leds_sh_q & {LED_COUNT{w_pwm_on}}
                   & (~mask_sh_q | {LED_COUNT{blink_phase_q}});
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            leds_sh_q     <= '0;
            mask_sh_q     <= '0;
            bright_sh_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            led_pins_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            leds_sh_q     <= leds_sh_d;
            mask_sh_q     <= mask_sh_d;
            bright_sh_q   <= bright_sh_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_pins_q    <= led_pins_d;
            frame_start_q <= w_load;
        end
    end

    assign led_pins    = led_pins_q;
    assign blink_phase = blink_phase_q;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire
